ssha_pipe: RTL
==============

Name: ssha_pipe

Overview:
- Parametrised, pipelined successor to the single-cycle SHA-256 sigma/sum unit.
- Computes all eight SHA-2 sigma/sum transforms: SHA-256 and SHA-512, each with sig0, sig1, sum0 and sum1.
- Supports XLEN of 32 or 64; on XLEN=32, SHA-512 transforms run on a register pair and return one half.
- Sits behind the crypto functional-unit issue port, with valid/ready handshakes on both sides.

Parameters:
- XLEN, 32, datapath width; legal values 32 or 64.
- STAGES, 1, pipeline depth; legal values 1 or 2. 1 = output register only; 2 = input register plus output register.

Ports:
- g_clk  in  1  clock; all state updates on the rising edge.
- g_reset  in  1  synchronous, active-high reset.
- flush  in  1  synchronous pipeline kill.
- in_valid  in  1  request valid.
- in_ready  out  1  unit can accept a request this cycle.
- op  in  3  transform select: 000 s256sig0, 001 s256sig1, 010 s256sum0, 011 s256sum1, 100 s512sig0, 101 s512sig1, 110 s512sum0, 111 s512sum1.
- hi  in  1  XLEN=32 SHA-512 only: 1 selects result[63:32], 0 selects result[31:0]; ignored otherwise.
- rs1  in  XLEN  source 1. For XLEN=32 SHA-512 ops it is the low half of the operand.
- rs2  in  XLEN  XLEN=32 SHA-512 ops: high half of the operand; ignored otherwise.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts the result.
- result  out  XLEN  transform result.

Behaviour:
- Transfers: a request is accepted when in_valid && in_ready; a result is consumed when out_valid && out_ready.
- SHA-256 functions (32-bit operand x = rs1[31:0]):
  - sig0 = ror7 ^ ror18 ^ srl3
  - sig1 = ror17 ^ ror19 ^ srl10
  - sum0 = ror2 ^ ror13 ^ ror22
  - sum1 = ror6 ^ ror11 ^ ror25
- SHA-512 functions (64-bit operand y = rs1 when XLEN=64, {rs2,rs1} when XLEN=32):
  - sig0 = ror1 ^ ror8 ^ srl7
  - sig1 = ror19 ^ ror61 ^ srl6
  - sum0 = ror28 ^ ror34 ^ ror39
  - sum1 = ror14 ^ ror18 ^ ror41
- Width rules:
  - XLEN=64, SHA-256 op: the 32-bit result is sign-extended from bit 31.
  - XLEN=32, SHA-512 op: the 64-bit result is halved per the hi latched with the request.
  - XLEN=64, SHA-512 op: the full 64-bit result is returned.
- Latency: STAGES cycles from accept to out_valid. Back-to-back throughput is 1 per cycle when out_ready is held high.
- Stage registers: each stage holds a valid bit plus payload.
  - STAGES=2: stage 1 holds op, hi and operand; transform logic sits between stage 1 and stage 2.
  - STAGES=1: transform logic sits between the input and the single stage.
- Stall rules:
  - A stage advances when its downstream slot is empty or is being consumed this cycle.
  - in_ready = !stage1_valid || stage1 advancing. Combinational from out_ready; no combinational path from in_valid.
  - While out_valid && !out_ready: result and out_valid hold stable, and no upstream stage overwrites a held entry.
- Reset (g_reset=1), next edge:
  - all stage valid bits = 0; out_valid = 0; result = 0; in_ready = 1 from the following cycle.
  - Reset mid-operation discards all in-flight requests; nothing is emitted.
- flush=1: same effect as reset on valid bits only (payload may keep stale values). A request presented in the same cycle as flush is not accepted; in_ready = 0 while flush=1.
- g_reset and flush together: reset wins (identical outcome).
- Payload is held in registers and is not required to be cleared, except result, which is 0 out of reset.
- Parameters outside their legal values fail elaboration with an error.

Test Plan:
- Vectors, XLEN=32, STAGES=1, out_ready=1, rs1=0x00000001, ops 000..011 -> results 0x02004000, 0x0000A000, 0x40080400, 0x04200080, each one cycle after accept.
- SHA-512 on XLEN=32, rs2=0, rs1=1, op=100 -> hi=1 gives 0x81000000; hi=0 gives 0x00000000. On XLEN=64 with rs1=1 -> 0x8100000000000000.
- Sign extension, XLEN=64, op=000, rs1=0x40 -> result 0xFFFFFFFF80100008.
- Backpressure, STAGES=2: stream 4 requests, hold out_ready=0 for 5 cycles -> in_ready drops after 2 accepts, result held stable; release -> all 4 results in order, no loss or duplication.
- Flush/reset, STAGES=2: flush with 2 entries in flight -> out_valid=0 next cycle and no stale result emitted. Assert g_reset mid-stream -> out_valid=0, result=0 after the edge, and in_ready=1 the following cycle.
- Random: 10k random op/hi/rs1/rs2 with random in_valid and out_ready, against a reference model, for all XLEN/STAGES combinations -> exact match and preserved order.

Source files
------------

// File: rtl/ssha_pipe.sv
// ssha_pipe: pipelined SHA-256/SHA-512 sigma and sum transforms behind a
// valid/ready issue port, for XLEN 32 or 64 with one or two pipeline stages.
module ssha_pipe #(
    parameter int XLEN   = 32,
    parameter int STAGES = 1
) (
    input  logic            g_clk,
    input  logic            g_reset,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [2:0]      op,
    input  logic            hi,
    input  logic [XLEN-1:0] rs1,
    input  logic [XLEN-1:0] rs2,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result
);

    generate
        if (XLEN != 32 && XLEN != 64) begin : g_bad_xlen
            $error("ssha_pipe: XLEN must be 32 or 64");
        end
        if (STAGES != 1 && STAGES != 2) begin : g_bad_stages
            $error("ssha_pipe: STAGES must be 1 or 2");
        end
    endgenerate

    function automatic logic [31:0] ror32(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic logic [63:0] ror64(input logic [63:0] y, input int n);
        return (y >> n) | (y << (64 - n));
    endfunction

    // SHA-256 results are sign-extended; on XLEN=32 a SHA-512 result is halved by h.
    function automatic logic [XLEN-1:0] transform(input logic [2:0] f, input logic h,
                                                  input logic [63:0] y);
        logic [31:0] x;
        logic [31:0] r32;
        logic [63:0] r64;
        logic [63:0] wide;
        x = y[31:0];
        case (f[1:0])
            2'b00:   r32 = ror32(x, 7) ^ ror32(x, 18) ^ (x >> 3);
            2'b01:   r32 = ror32(x, 17) ^ ror32(x, 19) ^ (x >> 10);
            2'b10:   r32 = ror32(x, 2) ^ ror32(x, 13) ^ ror32(x, 22);
            default: r32 = ror32(x, 6) ^ ror32(x, 11) ^ ror32(x, 25);
        endcase
        case (f[1:0])
            2'b00:   r64 = ror64(y, 1) ^ ror64(y, 8) ^ (y >> 7);
            2'b01:   r64 = ror64(y, 19) ^ ror64(y, 61) ^ (y >> 6);
            2'b10:   r64 = ror64(y, 28) ^ ror64(y, 34) ^ ror64(y, 39);
            default: r64 = ror64(y, 14) ^ ror64(y, 18) ^ ror64(y, 41);
        endcase
        if (!f[2]) begin
            wide = {{32{r32[31]}}, r32};
        end else if (XLEN == 32 && h) begin
            wide = {32'd0, r64[63:32]};
        end else begin
            wide = r64;
        end
        return wide[XLEN-1:0];
    endfunction

    logic [63:0]     in_operand;
    logic            accept;
    logic            s2_valid;
    logic [XLEN-1:0] s2_result;
    logic            s2_load;
    logic            up_valid;
    logic [XLEN-1:0] up_result;

    generate
        if (XLEN == 32) begin : g_operand32
            assign in_operand = {rs2, rs1};
        end else begin : g_operand64
            logic unused_rs2;
            assign unused_rs2 = ^rs2;
            assign in_operand = rs1[63:0];
        end
    endgenerate

    assign s2_load   = !s2_valid || out_ready;
    assign accept    = in_valid && in_ready;
    assign out_valid = s2_valid;
    assign result    = s2_result;

    generate
        if (STAGES == 2) begin : g_two_stage
            logic        s1_valid;
            logic [2:0]  s1_op;
            logic        s1_hi;
            logic [63:0] s1_operand;

            assign in_ready  = !flush && (!s1_valid || s2_load);
            assign up_valid  = s1_valid;
            assign up_result = transform(s1_op, s1_hi, s1_operand);

            always_ff @(posedge g_clk) begin
                if (g_reset || flush) begin
                    s1_valid <= 1'b0;
                end else begin
                    s1_valid <= accept || (s1_valid && !s2_load);
                end
            end

            // Payload is not cleared by reset; only the valid bit matters.
            always_ff @(posedge g_clk) begin
                if (accept) begin
                    s1_op      <= op;
                    s1_hi      <= hi;
                    s1_operand <= in_operand;
                end
            end
        end else begin : g_one_stage
            assign in_ready  = !flush && s2_load;
            assign up_valid  = accept;
            assign up_result = transform(op, hi, in_operand);
        end
    endgenerate

    // The result register only changes when a new entry lands, so it holds while stalled.
    always_ff @(posedge g_clk) begin
        if (g_reset) begin
            s2_valid  <= 1'b0;
            s2_result <= '0;
        end else if (flush) begin
            s2_valid <= 1'b0;
        end else if (s2_load) begin
            s2_valid <= up_valid;
            if (up_valid) begin
                s2_result <= up_result;
            end
        end
    end

endmodule
